// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive front end of the Morse encoder:
// FSM state encoding, default line settings, ASCII range constants and parity helper.
`timescale 1ns/1ps
package uart_rx_fifo_pkg;

   localparam int DEF_CLK_FREQ = 100_000_000;
   localparam int DEF_BAUD     = 9600;

   // Printable ranges the encoder knows how to translate.
   localparam logic [7:0] ASCII_SPACE   = 8'h20;
   localparam logic [7:0] ASCII_DIGIT_0 = 8'h30;
   localparam logic [7:0] ASCII_DIGIT_9 = 8'h39;
   localparam logic [7:0] ASCII_UPPER_A = 8'h41;
   localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;

   typedef enum logic [2:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_PARITY,
      UART_STOP,
      UART_BREAK
   } uart_state_e;

   function automatic logic calc_parity(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock circular buffer with show-ahead output, occupancy count
// and simultaneous push/pop (also when full). Reusable on the encoder output side.
`timescale 1ns/1ps
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // NOTE: storage has no reset; validity is carried entirely by count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (start + DATA_BITS + [parity] + stop) feeding a show-ahead FIFO.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int CLK_FREQ   = DEF_CLK_FREQ,
   parameter int BAUD       = DEF_BAUD,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx,
   input  logic                          rd_en,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overflow,
   output logic                          parity_err
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam int IDX_W        = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   logic                 rx_meta;
   logic                 rx_s;
   uart_state_e          state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_ok;
   logic                 bit_tick;
   logic                 stop_good;
   logic                 push;
   logic                 full;
   logic                 empty;

   // NOTE: the synchroniser resets to 1 (idle line) so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   assign bit_tick  = (cnt == LAST_CLK);
   assign stop_good = (state == UART_STOP) && bit_tick && rx_s && par_ok;
   // NOTE: push is decoded combinationally from the stop sample so the entry is visible one clock later.
   assign push      = stop_good && (!full || (rd_en && rd_valid));
   assign rd_valid  = !empty;

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_ok <= 1'b1;
      end else if (state == UART_PARITY && bit_tick) begin
         par_ok <= (rx_s == calc_parity(9'(shreg), PARITY_ODD != 0));
      end
   end
`else
   logic unused_parity_odd;
   assign par_ok            = 1'b1;
   assign unused_parity_odd = (PARITY_ODD != 0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= UART_IDLE;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
         parity_err <= 1'b0;
         cnt        <= cnt + 1'b1;
         case (state)
            UART_IDLE: begin
               cnt <= '0;
               if (!rx_s) state <= UART_START;
            end
            UART_START: begin
               if (cnt == HALF_BIT) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= rx_s ? UART_IDLE : UART_DATA;
               end
            end
            UART_DATA: begin
               if (bit_tick) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  idx   <= idx + 1'b1;
                  if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                     state <= UART_PARITY;
`else
                     state <= UART_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            UART_PARITY: begin
               if (bit_tick) begin
                  cnt   <= '0;
                  state <= UART_STOP;
               end
            end
`endif
            UART_STOP: begin
               if (bit_tick) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     frame_err <= 1'b1;
                     state     <= UART_BREAK;
                  end else begin
                     state <= UART_IDLE;
                     if (!par_ok)    parity_err <= 1'b1;
                     else if (!push) overflow   <= 1'b1;
                  end
               end
            end
            UART_BREAK: begin
               // A held-low line is reported once; wait for the line to return high.
               cnt <= '0;
               if (rx_s) state <= UART_IDLE;
            end
            default: state <= UART_IDLE;
         endcase
      end
   end

   sync_fifo #(
      .DATA_W (DATA_BITS),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (rd_en),
      .din   (shreg),
      .dout  (rd_data),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

endmodule
